// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and small decode helpers for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIVI,
        ST_DONE
    } state_t;

    // Divide-by-zero is resolved in one cycle, so only real MUL/DIV iterate.
    function automatic logic needs_iter(input logic [2:0] op, input logic b_nonzero);
        return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
module seq_alu_muldiv #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      count;
    logic               div_mode;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    // For DIV, acc holds {remainder, remaining dividend/quotient bits}.
    always_comb begin
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = trial - {1'b0, opb};
        acc_next = acc;
        if (div_mode) begin
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = acc + (opb[0] ? mcand : '0);
        end
    end

    // The final step's value is exposed so the owner can latch it on the same edge.
    assign done   = (count == CW'(1));
    assign result = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            div_mode <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
        end else if (start) begin
            count    <= CW'(WIDTH);
            div_mode <= is_div;
            opb      <= b;
            if (is_div) begin
                acc   <= {{WIDTH{1'b0}}, a};
                mcand <= '0;
            end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, a};
            end
        end else if (count != '0) begin
            count <= count - CW'(1);
            acc   <= acc_next;
            if (!div_mode) begin
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with valid/ready in and out; MUL/DIV iterate, everything else takes one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic                 out_overflow,
    output logic                 out_zero,
    output logic                 out_dbz,
    output logic                 busy
);

    state_t             state;
    logic               start;
    logic               md_done;
    logic [2*WIDTH-1:0] md_result;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] res_n;
    logic               carry_n;
    logic               ovf_n;
    logic               dbz_n;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign start    = in_ready && in_valid && needs_iter(in_op, in_b != '0);

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (in_op == OP_DIV),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        diff    = {1'b0, in_a} - {1'b0, in_b};
        res_n   = '0;
        carry_n = 1'b0;
        ovf_n   = 1'b0;
        dbz_n   = 1'b0;
        case (in_op)
            OP_ADD: begin
                res_n[WIDTH-1:0] = sum[WIDTH-1:0];
                carry_n          = sum[WIDTH];
                ovf_n            = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_n[WIDTH-1:0] = diff[WIDTH-1:0];
                carry_n          = ~diff[WIDTH];
                ovf_n            = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_DIV:  dbz_n = (in_b == '0);
            OP_AND:  res_n[WIDTH-1:0] = in_a & in_b;
            OP_OR:   res_n[WIDTH-1:0] = in_a | in_b;
            OP_XOR:  res_n[WIDTH-1:0] = in_a ^ in_b;
            OP_NOT:  res_n[WIDTH-1:0] = ~in_a;
            default: res_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_dbz      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (start) begin
                            state <= (in_op == OP_MUL) ? ST_MULT : ST_DIVI;
                        end else begin
                            state        <= ST_DONE;
                            out_valid    <= 1'b1;
                            out_result   <= res_n;
                            out_carry    <= carry_n;
                            out_overflow <= ovf_n;
                            out_zero     <= (res_n == '0);
                            out_dbz      <= dbz_n;
                        end
                    end
                end
                ST_MULT, ST_DIVI: begin
                    if (md_done) begin
                        state        <= ST_DONE;
                        out_valid    <= 1'b1;
                        out_result   <= md_result;
                        out_carry    <= 1'b0;
                        out_overflow <= 1'b0;
                        out_zero     <= (md_result == '0);
                        out_dbz      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed, scoreboarded bench for seq_alu at WIDTH=4, plus a WIDTH=8 instance for wide MUL/DIV.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic       ovf;
        logic       zero;
        logic       dbz;
        int         latency;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_overflow;
    logic       out_zero;
    logic       out_dbz;
    logic       busy;

    logic        in8_valid;
    logic        in8_ready;
    logic [2:0]  in8_op;
    logic [7:0]  in8_a;
    logic [7:0]  in8_b;
    logic        out8_valid;
    logic        out8_ready;
    logic [15:0] out8_result;
    logic        out8_carry;
    logic        out8_overflow;
    logic        out8_zero;
    logic        out8_dbz;
    logic        busy8;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    seq_alu #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
        .out_dbz(out_dbz), .busy(busy)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_op(in8_op), .in_a(in8_a), .in_b(in8_b),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_result(out8_result),
        .out_carry(out8_carry), .out_overflow(out8_overflow), .out_zero(out8_zero),
        .out_dbz(out8_dbz), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model works in plain integers rather than bit-slices.
    function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int ua, ub, sa, sb_, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        e.result = 8'd0; e.carry = 1'b0; e.ovf = 1'b0; e.dbz = 1'b0; e.latency = 1;
        case (op)
            OP_ADD: begin
                r = ua + ub;
                e.result = 8'(r % 16);
                e.carry  = (r > 15);
                e.ovf    = ((sa + sb_) > 7) || ((sa + sb_) < -8);
            end
            OP_SUB: begin
                r = ua - ub;
                e.result = 8'((r + 16) % 16);
                e.carry  = (ua >= ub);
                e.ovf    = ((sa - sb_) > 7) || ((sa - sb_) < -8);
            end
            OP_MUL: begin
                e.result  = 8'(ua * ub);
                e.latency = 5;
            end
            OP_DIV: begin
                if (ub == 0) e.dbz = 1'b1;
                else begin
                    e.result  = 8'((ua % ub) * 16 + ua / ub);
                    e.latency = 5;
                end
            end
            OP_AND:  e.result = 8'(ua & ub);
            OP_OR:   e.result = 8'(ua | ub);
            OP_XOR:  e.result = 8'(ua ^ ub);
            default: e.result = 8'((~ua) & 15);
        endcase
        e.zero = (e.result == 8'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input string tag);
        int waitc = 0;
        while (in_ready !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready"}, in_ready, 1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 4'($urandom);
        in_b = 4'($urandom);
        in_op = 3'($urandom);
    endtask

    task automatic checkOutput(input string tag);
        int   cycles = 1;
        exp_t e;
        while (out_valid !== 1'b1 && cycles < 40) begin
            check({tag, " busy"}, busy, 1);
            @(negedge clk);
            cycles++;
        end
        check({tag, " out_valid"}, out_valid, 1);
        e = sb.pop_front();
        check({tag, " result"}, out_result, e.result);
        check({tag, " carry"}, out_carry, e.carry);
        check({tag, " overflow"}, out_overflow, e.ovf);
        check({tag, " zero"}, out_zero, e.zero);
        check({tag, " dbz"}, out_dbz, e.dbz);
        check({tag, " latency"}, cycles, e.latency);
        check({tag, " in_ready low"}, in_ready, 0);
        if (out_ready) @(negedge clk);
    endtask

    task automatic checkWide(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_res, input string tag);
        int waitc = 0;
        int cycles = 1;
        while (in8_ready !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready"}, in8_ready, 1);
        in8_op = op; in8_a = a; in8_b = b; in8_valid = 1'b1;
        @(negedge clk);
        in8_valid = 1'b0;
        in8_a = 8'($urandom);
        in8_b = 8'($urandom);
        while (out8_valid !== 1'b1 && cycles < 60) begin
            check({tag, " busy"}, busy8, 1);
            @(negedge clk);
            cycles++;
        end
        check({tag, " out_valid"}, out8_valid, 1);
        check({tag, " result"}, out8_result, exp_res);
        check({tag, " flags"}, {out8_carry, out8_overflow, out8_dbz, out8_zero}, 4'b0000);
        check({tag, " latency"}, cycles, 9);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_op = '0; in8_a = '0; in8_b = '0; out8_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset result", out_result, 0);
        check("reset flags", {out_carry, out_overflow, out_zero, out_dbz}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(OP_ADD, 4'd9, 4'd8, "add 9+8");      checkOutput("add 9+8");
        applyStimulus(OP_SUB, 4'd3, 4'd5, "sub 3-5");      checkOutput("sub 3-5");
        applyStimulus(OP_SUB, 4'd5, 4'd5, "sub 5-5");      checkOutput("sub 5-5");
        applyStimulus(OP_MUL, 4'd15, 4'd15, "mul 15*15");  checkOutput("mul 15*15");
        applyStimulus(OP_DIV, 4'd13, 4'd4, "div 13/4");    checkOutput("div 13/4");
        applyStimulus(OP_DIV, 4'd7, 4'd0, "div 7/0");      checkOutput("div 7/0");
        applyStimulus(OP_DIV, 4'd5, 4'd7, "div 5/7");      checkOutput("div 5/7");
        applyStimulus(OP_MUL, 4'd0, 4'd9, "mul 0*9");      checkOutput("mul 0*9");
        applyStimulus(OP_ADD, 4'd7, 4'd1, "add 7+1");      checkOutput("add 7+1");
        applyStimulus(OP_SUB, 4'd8, 4'd1, "sub 8-1");      checkOutput("sub 8-1");
        applyStimulus(OP_AND, 4'hC, 4'hA, "and");          checkOutput("and");
        applyStimulus(OP_OR,  4'hC, 4'h3, "or");           checkOutput("or");
        applyStimulus(OP_XOR, 4'h5, 4'h5, "xor zero");     checkOutput("xor zero");
        applyStimulus(OP_NOT, 4'h5, 4'hF, "not");          checkOutput("not");

        // Backpressure: result must hold and new requests must be dropped.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 4'd2, 4'd3, "bp add");
        checkOutput("bp add");
        repeat (3) begin
            in_valid = 1'b1; in_op = OP_SUB; in_a = 4'd1; in_b = 4'd1;
            @(negedge clk);
            check("bp hold out_valid", out_valid, 1);
            check("bp hold result", out_result, 8'h05);
            check("bp hold flags", {out_carry, out_overflow, out_zero, out_dbz}, 4'b0000);
            check("bp hold in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready", in_ready, 1);
        check("bp release out_valid", out_valid, 0);
        applyStimulus(OP_XOR, 4'hC, 4'h3, "after bp");     checkOutput("after bp");

        // Reset on the second MULT cycle discards the operation.
        check("midrst in_ready", in_ready, 1);
        in_op = OP_MUL; in_a = 4'd3; in_b = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst result", out_result, 0);
        check("midrst busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no pulse", out_valid, 0);
        end
        applyStimulus(OP_ADD, 4'd1, 4'd1, "add 1+1");      checkOutput("add 1+1");

        checkWide(OP_MUL, 8'd255, 8'd255, 16'hFE01, "w8 mul 255*255");
        checkWide(OP_DIV, 8'd200, 8'd7, 16'h041C, "w8 div 200/7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
